// File: rtl/fft_output_serializer_if.sv
// rtl/fft_output_serializer_if.sv - frame load and beat stream signals of the FFT output serializer
interface fft_output_serializer_if #(
    parameter int P_WORD_BITS = 30,
    parameter int P_POINTS    = 32,
    parameter int P_IDX_BITS  = 5
);
    logic                            load;
    logic [P_POINTS*P_WORD_BITS-1:0] frame;
    logic                            in_ready;
    logic                            drop;
    logic                            valid;
    logic                            ready;
    logic [P_WORD_BITS-1:0]          data;
    logic [P_IDX_BITS-1:0]           index;
    logic                            last;

    modport master (
        input  load, frame, ready,
        output in_ready, drop, valid, data, index, last
    );

    modport slave (
        output load, frame, ready,
        input  in_ready, drop, valid, data, index, last
    );
endinterface

// File: rtl/fft_output_serializer.sv
// rtl/fft_output_serializer.sv - captures a 32-point FFT frame and streams it in natural bin order
module fft_output_serializer #(
    parameter int P_WORD_BITS   = 30,
    parameter int P_POINTS      = 32,
    parameter int P_IDX_BITS    = 5,
    parameter bit P_BIT_REVERSE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fft_output_serializer_if.master bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [P_IDX_BITS-1:0]  cnt_q;
    logic [P_WORD_BITS-1:0] buf_q [P_POINTS];
    logic                   drop_q;
    logic                   last_beat;
    logic                   take;
    logic                   accept;
    logic [P_IDX_BITS-1:0]  rd_idx;

    function automatic logic [P_IDX_BITS-1:0] bitrev(input logic [P_IDX_BITS-1:0] v);
        logic [P_IDX_BITS-1:0] r;
        for (int i = 0; i < P_IDX_BITS; i++) begin
            r[i] = v[P_IDX_BITS-1-i];
        end
        return r;
    endfunction

    assign last_beat = (cnt_q == P_IDX_BITS'(P_POINTS - 1));
    assign rd_idx    = P_BIT_REVERSE ? bitrev(cnt_q) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = STREAM;
            STREAM:  if (take && last_beat && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready opens on the last take so the next frame lands with no bubble
    always_comb begin
        bus.valid    = (state_q == STREAM);
        bus.last     = bus.valid & last_beat;
        bus.index    = cnt_q;
        bus.data     = bus.valid ? buf_q[rd_idx] : '0;
        bus.drop     = drop_q;
        take         = bus.valid & bus.ready;
        bus.in_ready = (state_q == IDLE) | (take & last_beat);
        accept       = bus.load & bus.in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
            for (int n = 0; n < P_POINTS; n++) begin
                buf_q[n] <= '0;
            end
        end else begin
            drop_q <= bus.load & ~bus.in_ready;
            if (accept) begin
                cnt_q <= '0;
                for (int n = 0; n < P_POINTS; n++) begin
                    buf_q[n] <= bus.frame[n*P_WORD_BITS +: P_WORD_BITS];
                end
            end else if (take) begin
                cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fft_output_serializer.sv
// tb/tb_fft_output_serializer.sv - randomized and directed checks of the FFT output serializer
module tb_fft_output_serializer;
    localparam int W = 30;
    localparam int N = 32;
    localparam int B = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         ready = 1'b1;
    logic [N*W-1:0] frame = '0;
    logic [W-1:0] fw [N];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] d_rev;
        logic [W-1:0] d_nat;
        int           idx;
    } beat_t;
    beat_t q[$];
    logic  exp_drop = 1'b0;

    always #5 clk = ~clk;

    fft_output_serializer_if #(.P_WORD_BITS(W), .P_POINTS(N), .P_IDX_BITS(B)) if_r ();
    fft_output_serializer_if #(.P_WORD_BITS(W), .P_POINTS(N), .P_IDX_BITS(B)) if_n ();

    assign if_r.load  = load;
    assign if_r.frame = frame;
    assign if_r.ready = ready;
    assign if_n.load  = load;
    assign if_n.frame = frame;
    assign if_n.ready = ready;

    fft_output_serializer #(.P_WORD_BITS(W), .P_POINTS(N), .P_IDX_BITS(B), .P_BIT_REVERSE(1'b1))
        dut_rev (.clk(clk), .rst_n(rst_n), .bus(if_r.master));
    fft_output_serializer #(.P_WORD_BITS(W), .P_POINTS(N), .P_IDX_BITS(B), .P_BIT_REVERSE(1'b0))
        dut_nat (.clk(clk), .rst_n(rst_n), .bus(if_n.master));

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < B; i++) begin
            r = r * 2 + ((k >> i) & 1);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_frame(input int mode, input int base);
        for (int n = 0; n < N; n++) begin
            fw[n] = (mode == 0) ? W'(n + base) : W'($urandom);
            frame[n*W +: W] = fw[n];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a queue of beats still owed; a frame is accepted when nothing is owed
    // or the only owed beat is the last one and it is being taken right now.
    always @(negedge clk) begin
        logic has;
        logic pred_ready;
        if (!rst_n) begin
            q.delete();
            exp_drop = 1'b0;
            chk("rst_valid", {if_r.valid, if_n.valid}, 2'b00);
            chk("rst_data", {if_r.data, if_n.data}, '0);
            chk("rst_index_last", {if_r.index, if_r.last, if_n.index, if_n.last}, '0);
            chk("rst_drop", {if_r.drop, if_n.drop}, 2'b00);
            chk("rst_in_ready", {if_r.in_ready, if_n.in_ready}, 2'b11);
        end else begin
            has        = (q.size() > 0);
            pred_ready = !has || (q[0].idx == N - 1 && ready);
            chk("valid", {if_r.valid, if_n.valid}, {has, has});
            if (has) begin
                chk("data_rev", if_r.data, q[0].d_rev);
                chk("data_nat", if_n.data, q[0].d_nat);
                chk("index", {if_r.index, if_n.index}, {B'(q[0].idx), B'(q[0].idx)});
                chk("last", {if_r.last, if_n.last}, {2{q[0].idx == N - 1}});
            end
            chk("in_ready", {if_r.in_ready, if_n.in_ready}, {pred_ready, pred_ready});
            chk("drop", {if_r.drop, if_n.drop}, {exp_drop, exp_drop});
            exp_drop = load && !pred_ready;
            if (has && ready) void'(q.pop_front());
            if (load && pred_ready) begin
                for (int k = 0; k < N; k++) begin
                    beat_t b;
                    b.d_rev = fw[brev(k)];
                    b.d_nat = fw[k];
                    b.idx   = k;
                    q.push_back(b);
                end
            end
        end
    end

    initial begin
        set_frame(0, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // natural-valued frame: bit-reversed and natural orders pinned by literals
        load = 1'b1;
        step();
        load = 1'b0;
        @(negedge clk);
        chk("t1_b0", {if_r.valid, if_r.data, if_n.data}, {1'b1, 30'd0, 30'd0});
        @(negedge clk);
        chk("t1_b1", {if_r.data, if_n.data}, {30'd16, 30'd1});
        @(negedge clk);
        chk("t1_b2", {if_r.data, if_n.data}, {30'd8, 30'd2});
        @(negedge clk);
        chk("t1_b3", {if_r.data, if_r.index}, {30'd24, 5'd3});
        repeat (40) step();

        // stall at beat 5 for three cycles
        set_frame(1, 0);
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (5) step();
        ready = 1'b0;
        repeat (3) step();
        chk("t3_frozen_idx", if_r.index, 5'd5);
        ready = 1'b1;
        repeat (40) step();

        // back-to-back frames: B loads on A's last take
        set_frame(0, 0);
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (31) step();
        set_frame(0, 100);
        load = 1'b1;
        #1;
        chk("t4_in_ready", if_r.in_ready, 1'b1);
        step();
        load = 1'b0;
        @(negedge clk);
        chk("t4_b0", {if_r.valid, if_r.data, if_r.index}, {1'b1, 30'd100, 5'd0});
        repeat (40) step();

        // load during a stream is dropped
        set_frame(1, 0);
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();
        load = 1'b1;
        #1;
        chk("t5_in_ready", if_r.in_ready, 1'b0);
        step();
        load = 1'b0;
        @(negedge clk);
        chk("t5_drop", {if_r.drop, if_r.index}, {1'b1, 5'd11});
        repeat (40) step();

        // asynchronous reset mid-frame
        set_frame(1, 0);
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (12) step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {if_r.valid, if_n.valid}, 2'b00);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t6_idle_ready", if_r.in_ready, 1'b1);
        set_frame(0, 7);
        load = 1'b1;
        step();
        load = 1'b0;
        @(negedge clk);
        chk("t6_restart", {if_r.data, if_r.index}, {30'd7, 5'd0});
        repeat (40) step();

        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom % 4) != 0;
            load  = ($urandom % 8) == 0;
            if (load) set_frame(1, 0);
            step();
        end
        load  = 1'b0;
        ready = 1'b1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
